// File: rtl/pi_loop_clamped_if.sv
// Converter handshake bundle between the PI loop controller (master) and the
// ADC/DAC front-end (slave).
interface pi_loop_clamped_if #(
    parameter int ADC_WID      = 18,
    parameter int DAC_DATA_WID = 20
);
    logic signed [ADC_WID-1:0]      adc_val;
    logic                           adc_arm;
    logic                           adc_fin;
    logic signed [DAC_DATA_WID-1:0] dac_val;
    logic                           dac_arm;
    logic                           dac_fin;

    modport master (
        input  adc_val, adc_fin, dac_fin,
        output adc_arm, dac_val, dac_arm
    );

    modport slave (
        output adc_val, adc_fin, dac_fin,
        input  adc_arm, dac_val, dac_arm
    );
endinterface

// File: rtl/pi_loop_clamped.sv
// Sequential PI controller: sample ADC, serial-multiply alpha*e and P*e_prev,
// accumulate with anti-windup, clamp, then write the DAC.
module pi_loop_clamped #(
    parameter int ADC_WID         = 18,
    parameter int DAC_DATA_WID    = 20,
    parameter int CONSTS_WID      = 48,
    parameter int CONSTS_FRAC_WID = 33,
    parameter int DELAY_WID       = 16
) (
    input  logic                           clk,
    input  logic                           rst_L,
    input  logic                           run,
    input  logic signed [ADC_WID-1:0]      setpt,
    input  logic signed [CONSTS_WID-1:0]   alpha,
    input  logic signed [CONSTS_WID-1:0]   p,
    input  logic        [DELAY_WID-1:0]    dely,
    input  logic signed [DAC_DATA_WID-1:0] out_min,
    input  logic signed [DAC_DATA_WID-1:0] out_max,
    input  logic signed [DAC_DATA_WID-1:0] init_val,
    output logic                           running,
    output logic signed [ADC_WID:0]        err_out,
    output logic                           sat_hi,
    output logic                           sat_lo,
    output logic        [31:0]             cycle_cnt,
    pi_loop_clamped_if.master              cnv
);

    localparam int EW    = ADC_WID + 1;
    localparam int DW    = DAC_DATA_WID;
    localparam int PW    = CONSTS_WID + EW;
    localparam int AW    = PW + 1;
    localparam int QW    = AW - CONSTS_FRAC_WID;
    localparam int YW    = ((QW > DW) ? QW : DW) + 1;
    localparam int CNT_W = $clog2(EW);

    typedef enum logic [2:0] {
        IDLE, WAIT_DELAY, ADC, MUL_A, MUL_P, SUM, DAC
    } state_t;

    state_t                 state, state_nxt;
    logic [DELAY_WID-1:0]   timer;
    logic [CNT_W-1:0]       bit_cnt;
    logic signed [DW-1:0]   base, out_min_s, out_max_s, dac_val_r, y_clamped;
    logic signed [ADC_WID-1:0]    setpt_s;
    logic signed [CONSTS_WID-1:0] alpha_s, p_s;
    logic signed [EW-1:0]   err_cur, err_prev, err_calc;
    logic signed [PW-1:0]   mcand, prod, prod_alpha, mul_term, prod_nxt;
    logic [EW-1:0]          mplier;
    logic signed [AW-1:0]   acc, acc_new;
    logic signed [YW-1:0]   y;
    logic                   clamp_hi, clamp_lo, consts_changed, mul_last, wait_done;

    // Floor-scale the accumulator to integer DAC units and add the base.
    function automatic logic signed [YW-1:0] scale_out(
        input logic signed [AW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic signed [AW-1:0] q;
        q = a >>> CONSTS_FRAC_WID;
        return YW'(q) + YW'(b);
    endfunction

    // Returns {hi_flag, lo_flag, value}; inverted limits resolve to out_min.
    function automatic logic [DW+1:0] clamp_out(
        input logic signed [YW-1:0] v,
        input logic signed [DW-1:0] mn,
        input logic signed [DW-1:0] mx
    );
        logic signed [YW-1:0] mn_x, mx_x;
        mn_x = YW'(mn);
        mx_x = YW'(mx);
        if (mn > mx)
            return {2'b01, mn};
        else if (v > mx_x)
            return {2'b10, mx};
        else if (v < mn_x)
            return {2'b01, mn};
        else
            return {2'b00, v[DW-1:0]};
    endfunction

    assign wait_done = (timer >= dely);
    assign mul_last  = (bit_cnt == CNT_W'(EW - 1));
    assign running   = (state != IDLE);
    assign cnv.adc_arm = (state == ADC);
    assign cnv.dac_arm = (state == DAC);
    assign cnv.dac_val = dac_val_r;

    always_comb begin
        consts_changed = (setpt != setpt_s) || (alpha != alpha_s) || (p != p_s) ||
                         (out_min != out_min_s) || (out_max != out_max_s);
        err_calc = $signed({cnv.adc_val[ADC_WID-1], cnv.adc_val}) -
                   $signed({setpt_s[ADC_WID-1], setpt_s});
        // The multiplier's MSB carries negative weight, so the last step subtracts.
        mul_term = mplier[0] ? mcand : '0;
        prod_nxt = mul_last ? (prod - mul_term) : (prod + mul_term);
        acc_new  = acc + AW'(prod_alpha) - AW'(prod);
        y        = scale_out(acc_new, base);
        {clamp_hi, clamp_lo, y_clamped} = clamp_out(y, out_min_s, out_max_s);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (run) state_nxt = WAIT_DELAY;
            WAIT_DELAY: if (!run) state_nxt = IDLE;
                        else if (wait_done) state_nxt = ADC;
            ADC:        if (cnv.adc_fin) state_nxt = MUL_A;
            MUL_A:      if (mul_last) state_nxt = MUL_P;
            MUL_P:      if (mul_last) state_nxt = SUM;
            SUM:        state_nxt = DAC;
            DAC:        if (cnv.dac_fin) state_nxt = WAIT_DELAY;
            default:    state_nxt = IDLE;
        endcase
    end

    // Operand sampling and the shift-add multiplier; no reset needed here.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (run) begin
                    base      <= init_val;
                    setpt_s   <= setpt;
                    alpha_s   <= alpha;
                    p_s       <= p;
                    out_min_s <= out_min;
                    out_max_s <= out_max;
                end
            end
            WAIT_DELAY: begin
                if (run && wait_done) begin
                    setpt_s   <= setpt;
                    alpha_s   <= alpha;
                    p_s       <= p;
                    out_min_s <= out_min;
                    out_max_s <= out_max;
                end
            end
            ADC: begin
                if (cnv.adc_fin) begin
                    err_cur <= err_calc;
                    mcand   <= PW'(alpha_s);
                    mplier  <= err_calc;
                    prod    <= '0;
                end
            end
            MUL_A: begin
                if (mul_last) begin
                    prod_alpha <= prod_nxt;
                    mcand      <= PW'(p_s);
                    mplier     <= err_prev;
                    prod       <= '0;
                end else begin
                    mcand  <= mcand <<< 1;
                    mplier <= mplier >> 1;
                    prod   <= prod_nxt;
                end
            end
            MUL_P: begin
                mcand  <= mcand <<< 1;
                mplier <= mplier >> 1;
                prod   <= prod_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            timer     <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            err_prev  <= '0;
            cycle_cnt <= '0;
            dac_val_r <= '0;
            err_out   <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        acc       <= '0;
                        err_prev  <= '0;
                        cycle_cnt <= '0;
                        timer     <= '0;
                    end
                end
                WAIT_DELAY: begin
                    if (run) begin
                        if (wait_done) begin
                            // A retuned loop must not inherit history from the old gains.
                            if (consts_changed) begin
                                acc      <= '0;
                                err_prev <= '0;
                            end
                        end else begin
                            timer <= timer + DELAY_WID'(1);
                        end
                    end
                end
                ADC: begin
                    if (cnv.adc_fin) bit_cnt <= '0;
                end
                MUL_A, MUL_P: begin
                    bit_cnt <= mul_last ? '0 : bit_cnt + CNT_W'(1);
                end
                SUM: begin
                    if (!(clamp_hi || clamp_lo)) acc <= acc_new;
                    err_prev  <= err_cur;
                    dac_val_r <= y_clamped;
                    sat_hi    <= clamp_hi;
                    sat_lo    <= clamp_lo;
                end
                DAC: begin
                    if (cnv.dac_fin) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                        err_out   <= err_cur;
                        timer     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pi_loop_clamped.md
PI_LOOP_CLAMPED -- requirements
Module: pi_loop_clamped

Interface
REQ-001 SHALL have parameter ADC_WID, default 18: signed ADC sample width.
REQ-002 SHALL have parameter DAC_DATA_WID, default 20: signed DAC code width; ERR_WID = ADC_WID+1.
REQ-003 SHALL have parameter CONSTS_WID, default 48: signed gain width.
REQ-004 SHALL have parameter CONSTS_FRAC_WID, default 33: fractional bits of gains and accumulator.
REQ-005 SHALL have parameter DELAY_WID, default 16: inter-cycle delay counter width.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have the following ports:
- clk  in  1  system clock, all state on rising edge
- rst_L  in  1  asynchronous active-low reset
- run  in  1  enable loop
- setpt  in  ADC_WID  signed setpoint
- alpha  in  CONSTS_WID  signed α = P+IΔt, CONSTS_FRAC_WID frac bits
- p  in  CONSTS_WID  signed P, same format
- dely  in  DELAY_WID  idle clocks between cycles
- out_min, out_max  in  DAC_DATA_WID each  signed clamp limits
- init_val  in  DAC_DATA_WID  signed output base latched at start
- adc_val  in  ADC_WID  signed measurement
- adc_arm  out  1  request conversion
- adc_fin  in  1  conversion done
- dac_val  out  DAC_DATA_WID  code to DAC
- dac_arm  out  1  request write
- dac_fin  in  1  write done
- running  out  1  high outside IDLE
- err_out  out  ERR_WID  last error
- sat_hi, sat_lo  out  1 each  last output clamped high/low
- cycle_cnt  out  32  completed cycles since leaving IDLE, wraps

Function
REQ-008 SHALL implement states IDLE, WAIT_DELAY, ADC, MUL_A, MUL_P, SUM, DAC.
REQ-009 IDLE: on run=1 SHALL latch init_val as base, clear acc, err_prev, cycle_cnt, sample constants, enter WAIT_DELAY with timer 0.
REQ-010 WAIT_DELAY: run=0 -> IDLE; else timer<dely increments; timer==dely -> ADC, adc_arm=1 next clock.
REQ-011 On leaving WAIT_DELAY, SHALL resample setpt, alpha, p, out_min, out_max; any change vs previous sample clears acc and err_prev.
REQ-012 ADC: adc_arm held until adc_fin=1; that clock captures e = adc_val - setpt (ERR_WID signed, exact), drops adc_arm, enters MUL_A.
REQ-013 MUL_A SHALL compute α·e with a serial signed multiplier shared with MUL_P, exactly ERR_WID clocks, product CONSTS_WID+ERR_WID bits, exact.
REQ-014 MUL_P SHALL compute P·err_prev on the same multiplier, exactly ERR_WID clocks.
REQ-015 SUM (one clock): acc_new = acc + α·e − P·err_prev, width CONSTS_WID+ERR_WID+1; y = base + (acc_new >>> CONSTS_FRAC_WID) (floor), sign-extended, no wrap.
REQ-016 Clamp: y>out_max -> out_max, sat_hi=1; else y<out_min -> out_min, sat_lo=1; else y, both flags 0; if out_min>out_max result is out_min.
REQ-017 Anti-windup: on clamp acc SHALL keep old value; else acc<=acc_new; err_prev<=e always.
REQ-018 DAC: dac_val driven with clamped value, dac_arm held until dac_fin; that clock drops dac_arm, increments cycle_cnt, updates err_out, enters WAIT_DELAY, timer 0.
REQ-019 run=0 during ADC..DAC SHALL not abort; cycle completes, IDLE taken from WAIT_DELAY.
REQ-020 adc_fin outside ADC and dac_fin outside DAC SHALL be ignored.
REQ-021 dely=0: adc_arm SHALL rise the clock after DAC completion plus one WAIT_DELAY clock.

Reset
REQ-022 rst_L=0 SHALL immediately force IDLE and adc_arm=dac_arm=running=sat_hi=sat_lo=0, dac_val=err_out=0, cycle_cnt=0, acc=err_prev=0, regardless of state.
REQ-023 Reset mid-handshake SHALL not require adc_fin/dac_fin; after release loop restarts only via REQ-009.

Verification
REQ-024 alpha=1<<33, p=0, setpt=0, adc_val=5, init_val=100, limits ±2^19-1 -> dac_val 105, 110, 115; cycle_cnt 1,2,3.
REQ-025 As REQ-024, out_max=107 -> 105, then 107 with sat_hi=1 every cycle, acc held at 5.0.
REQ-026 alpha=p=1<<33, adc_val 4 then 4 -> second cycle acc unchanged, dac_val=104 both cycles.
REQ-027 dely=3 -> exactly 4 clocks from dac_fin clock to adc_arm rise; ERR_WID clocks in each of MUL_A, MUL_P.
REQ-028 Change setpt mid-run from 0 to 2 -> next cycle acc cleared, dac_val=init_val+3 with adc_val=5.
REQ-029 rst_L low while dac_arm=1 -> dac_arm low same clock, all outputs at reset values, run=1 after release restarts at IDLE.
